reaction_seq_ctrl: RTL and testbench



---
 rtl/reaction_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_reaction_seq_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_seq_ctrl.sv
// reaction_seq_ctrl: round sequencer for the reaction-timer game.
// Define BEST_TIME_EN to keep a best-valid-time register; otherwise best_time is all ones.
module reaction_seq_ctrl #(
    parameter int N_LEDS    = 10,
    parameter int TIME_W    = 16,
    parameter int MIN_DELAY = 250,
    parameter int MAX_TIME  = 9999
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_ms,
    input  logic              tick_hs,
    input  logic              key_n,
    input  logic [13:0]       rnd,
    output logic              lfsr_en,
    output logic [N_LEDS-1:0] ledr,
    output logic [TIME_W-1:0] react_time,
    output logic              result_valid,
    output logic              false_start,
    output logic [TIME_W-1:0] best_time
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LIGHTS,
        S_WAIT,
        S_TIMING,
        S_SHOW,
        S_FALSE
    } state_t;

    localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);
    localparam logic [14:0]       MIN_D = 15'(MIN_DELAY);

    state_t            state_q, state_d;
    logic              key_q;
    logic              press;
    logic [N_LEDS-1:0] ledr_q, ledr_d, alt_pat;
    logic [14:0]       delay_cnt_q, delay_cnt_d;
    logic [TIME_W-1:0] react_cnt_q, react_cnt_d, react_inc;
    logic [TIME_W-1:0] react_time_q, react_time_d;
    logic              result_valid_q, result_valid_d;

    for (genvar i = 0; i < N_LEDS; i++) begin : g_alt
        assign alt_pat[i] = (i % 2) == 1;
    end

    assign press = key_q & ~key_n;

    // Saturating ms count, including a tick that lands with the press.
    assign react_inc = (tick_ms && react_cnt_q != MAX_T)
                     ? react_cnt_q + TIME_W'(1) : react_cnt_q;

    always_comb begin
        state_d        = state_q;
        ledr_d         = ledr_q;
        delay_cnt_d    = delay_cnt_q;
        react_cnt_d    = react_cnt_q;
        react_time_d   = react_time_q;
        result_valid_d = result_valid_q;
        unique case (state_q)
            S_IDLE: begin
                ledr_d = '0;
                if (press) begin
                    state_d      = S_LIGHTS;
                    react_time_d = '0;
                end
            end
            S_LIGHTS: begin
                if (press) begin
                    state_d      = S_FALSE;
                    ledr_d       = alt_pat;
                    react_time_d = '0;
                end else if (tick_hs) begin
                    ledr_d = {ledr_q[N_LEDS-2:0], 1'b1};
                    if (ledr_q[N_LEDS-2]) begin
                        state_d     = S_WAIT;
                        delay_cnt_d = MIN_D + {1'b0, rnd};
                    end
                end
            end
            S_WAIT: begin
                if (press) begin
                    state_d      = S_FALSE;
                    ledr_d       = alt_pat;
                    react_time_d = '0;
                end else if (tick_ms) begin
                    if (delay_cnt_q <= 15'd1) begin
                        state_d      = S_TIMING;
                        ledr_d       = '0;
                        delay_cnt_d  = '0;
                        react_cnt_d  = '0;
                        react_time_d = '0;
                    end else begin
                        delay_cnt_d = delay_cnt_q - 15'd1;
                    end
                end
            end
            S_TIMING: begin
                react_cnt_d  = react_inc;
                react_time_d = react_inc;
                if (press) begin
                    state_d        = S_SHOW;
                    result_valid_d = 1'b1;
                end else if (react_inc == MAX_T) begin
                    state_d        = S_SHOW;
                    result_valid_d = 1'b0;
                end
            end
            S_SHOW: begin
                if (press) begin
                    state_d        = S_LIGHTS;
                    ledr_d         = '0;
                    react_time_d   = '0;
                    result_valid_d = 1'b0;
                end
            end
            S_FALSE: begin
                if (press) begin
                    state_d      = S_LIGHTS;
                    ledr_d       = '0;
                    react_time_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ledr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            key_q          <= 1'b1;
            ledr_q         <= '0;
            delay_cnt_q    <= '0;
            react_cnt_q    <= '0;
            react_time_q   <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_q          <= key_n;
            ledr_q         <= ledr_d;
            delay_cnt_q    <= delay_cnt_d;
            react_cnt_q    <= react_cnt_d;
            react_time_q   <= react_time_d;
            result_valid_q <= result_valid_d;
        end
    end

`ifdef BEST_TIME_EN
    logic [TIME_W-1:0] best_q, best_d;

    // react_time is frozen in SHOW, so re-applying the min is harmless.
    always_comb begin
        best_d = best_q;
        if (state_q == S_SHOW && result_valid_q && react_time_q < best_q)
            best_d = react_time_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) best_q <= '1;
        else        best_q <= best_d;
    end

    assign best_time = best_q;
`else
    assign best_time = '1;
`endif

    assign lfsr_en      = (state_q == S_IDLE) || (state_q == S_LIGHTS);
    assign false_start  = (state_q == S_FALSE);
    assign ledr         = ledr_q;
    assign react_time   = react_time_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_reaction_seq_ctrl.sv
// Bench for reaction_seq_ctrl: directed vector table plus randomized rounds.
// Expected best_time follows BEST_TIME_EN when the bench is built with it.
module tb_reaction_seq_ctrl;

`ifdef BEST_TIME_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif
    localparam int N   = 10;
    localparam int FF  = 65535;
    localparam int ALT = 'h2AA;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_ms = 1'b0;
    logic        tick_hs = 1'b0;
    logic        key_n = 1'b1;
    logic [13:0] rnd = '0;
    logic        lfsr_en;
    logic [9:0]  ledr;
    logic [15:0] react_time;
    logic        result_valid;
    logic        false_start;
    logic [15:0] best_time;

    int total = 0;
    int bad   = 0;
    int best_m = FF;

    reaction_seq_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick_ms(tick_ms),
        .tick_hs(tick_hs),
        .key_n(key_n),
        .rnd(rnd),
        .lfsr_en(lfsr_en),
        .ledr(ledr),
        .react_time(react_time),
        .result_valid(result_valid),
        .false_start(false_start),
        .best_time(best_time)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int    n;
        bit    ms;
        bit    hs;
        bit    key;
        int    l;
        int    rt;
        int    rv;
        int    fs;
        int    le;
        int    b;
    } vec_t;

    vec_t tbl[$];

    function automatic int bexp(input int v);
        return BEST_EN ? v : FF;
    endfunction

    task automatic add(input string nm, input int n, input bit ms,
                       input bit hs, input bit key, input int l,
                       input int rt, input int rv, input int fs,
                       input int le, input int b);
        vec_t v;
        v = '{nm, n, ms, hs, key, l, rt, rv, fs, le, b};
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int l, input int rt,
                           input int rv, input int fs, input int le,
                           input int b);
        chk({nm, ".ledr"}, int'(ledr), l);
        chk({nm, ".react_time"}, int'(react_time), rt);
        chk({nm, ".result_valid"}, int'(result_valid), rv);
        chk({nm, ".false_start"}, int'(false_start), fs);
        chk({nm, ".lfsr_en"}, int'(lfsr_en), le);
        chk({nm, ".best_time"}, int'(best_time), b);
    endtask

    // One clock: inputs applied at negedge, outputs visible #1 after posedge.
    task automatic step(input bit ms, input bit hs, input bit key);
        @(negedge clk);
        tick_ms = ms;
        tick_hs = hs;
        key_n   = key;
        @(posedge clk);
        #1;
        tick_ms = 1'b0;
        tick_hs = 1'b0;
    endtask

    task automatic hs_tick();
        step(1'($urandom_range(0, 1)), 1'b1, 1'b1);
        if ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic ms_tick();
        step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b1);
    endtask

    // kind 0: false start in lights after k ticks; 1: false start in wait
    // after k ms; 2: valid reaction of t ms (co = press shares a tick).
    task automatic do_round(input int kind, input int r, input int k,
                            input bit co, input int t);
        int dly;
        dly = 250 + r;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("rnd.start.ledr", int'(ledr), 0);
        chk("rnd.start.lfsr_en", int'(lfsr_en), 1);
        chk("rnd.start.rv", int'(result_valid), 0);
        chk("rnd.start.fs", int'(false_start), 0);
        rnd = 14'(r);
        if (kind == 0) begin
            repeat (k) hs_tick();
            chk("rnd.lights.ledr", int'(ledr), (1 << k) - 1);
            step(1'b0, co, 1'b0);
            step(1'b0, 1'b0, 1'b1);
            chk_all("rnd.fs_lights", ALT, 0, 0, 1, 0, bexp(best_m));
            return;
        end
        repeat (N) hs_tick();
        rnd = 14'($urandom);
        chk("rnd.wait.ledr", int'(ledr), 'h3FF);
        chk("rnd.wait.lfsr_en", int'(lfsr_en), 0);
        if (kind == 1) begin
            repeat (k) ms_tick();
            step(co, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b1);
            chk_all("rnd.fs_wait", ALT, 0, 0, 1, 0, bexp(best_m));
            return;
        end
        repeat (dly - 1) ms_tick();
        chk("rnd.wait_end.ledr", int'(ledr), 'h3FF);
        ms_tick();
        chk("rnd.go.ledr", int'(ledr), 0);
        chk("rnd.go.rt", int'(react_time), 0);
        repeat (t - int'(co)) ms_tick();
        step(co, 1'b0, 1'b0);
        chk("rnd.hit.rt", int'(react_time), t);
        chk("rnd.hit.rv", int'(result_valid), 1);
        step(1'b0, 1'b0, 1'b1);
        if (t < best_m) best_m = t;
        chk_all("rnd.show", 0, t, 1, 0, 0, bexp(best_m));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int kind, r, k, t;
        bit co;

        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 1, FF);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        chk_all("idle_ticks", 0, 0, 0, 0, 1, FF);

        add("press",      1,    0, 0, 0, 0,     0,    0, 0, 1, FF);
        add("rel",        1,    0, 0, 1, 0,     0,    0, 0, 1, FF);
        add("hs9",        9,    0, 1, 1, 'h1FF, 0,    0, 0, 1, FF);
        add("hs10",       1,    0, 1, 1, 'h3FF, 0,    0, 0, 0, FF);
        add("ms254",      254,  1, 0, 1, 'h3FF, 0,    0, 0, 0, FF);
        add("ms255",      1,    1, 0, 1, 0,     0,    0, 0, 0, FF);
        add("ms123",      123,  1, 0, 1, 0,     123,  0, 0, 0, FF);
        add("hit123",     1,    0, 0, 0, 0,     123,  1, 0, 0, FF);
        add("show123",    1,    0, 0, 1, 0,     123,  1, 0, 0, bexp(123));
        add("show_ign",   5,    1, 1, 1, 0,     123,  1, 0, 0, bexp(123));
        add("restart",    1,    0, 0, 0, 0,     0,    0, 0, 1, bexp(123));
        add("rel2",       1,    0, 0, 1, 0,     0,    0, 0, 1, bexp(123));
        add("hs3",        3,    0, 1, 1, 'h007, 0,    0, 0, 1, bexp(123));
        add("fs_hs",      1,    0, 1, 0, ALT,   0,    0, 1, 0, bexp(123));
        add("fs_rel",     1,    0, 0, 1, ALT,   0,    0, 1, 0, bexp(123));
        add("fs_ign",     4,    1, 1, 1, ALT,   0,    0, 1, 0, bexp(123));
        add("fs_exit",    1,    0, 0, 0, 0,     0,    0, 0, 1, bexp(123));
        add("rel3",       1,    0, 0, 1, 0,     0,    0, 0, 1, bexp(123));
        add("hs10b",      10,   0, 1, 1, 'h3FF, 0,    0, 0, 0, bexp(123));
        add("fs_wait",    1,    1, 0, 0, ALT,   0,    0, 1, 0, bexp(123));
        add("rel4",       1,    0, 0, 1, ALT,   0,    0, 1, 0, bexp(123));
        add("fs_exit2",   1,    0, 0, 0, 0,     0,    0, 0, 1, bexp(123));
        add("rel5",       1,    0, 0, 1, 0,     0,    0, 0, 1, bexp(123));
        add("hs10c",      10,   0, 1, 1, 'h3FF, 0,    0, 0, 0, bexp(123));
        add("ms255c",     255,  1, 0, 1, 0,     0,    0, 0, 0, bexp(123));
        add("ms39",       39,   1, 0, 1, 0,     39,   0, 0, 0, bexp(123));
        add("hit40_co",   1,    1, 0, 0, 0,     40,   1, 0, 0, bexp(123));
        add("hold1000",   1000, 1, 1, 0, 0,     40,   1, 0, 0, bexp(40));
        add("rel6",       1,    0, 0, 1, 0,     40,   1, 0, 0, bexp(40));
        add("restart2",   1,    0, 0, 0, 0,     0,    0, 0, 1, bexp(40));
        add("rel7",       1,    0, 0, 1, 0,     0,    0, 0, 1, bexp(40));
        add("hs10d",      10,   0, 1, 1, 'h3FF, 0,    0, 0, 0, bexp(40));
        add("ms255d",     255,  1, 0, 1, 0,     0,    0, 0, 0, bexp(40));
        add("ms9998",     9998, 1, 0, 1, 0,     9998, 0, 0, 0, bexp(40));
        add("timeout",    1,    1, 0, 1, 0,     9999, 0, 0, 0, bexp(40));
        add("to_ign",     5,    1, 0, 1, 0,     9999, 0, 0, 0, bexp(40));
        add("to_exit",    1,    0, 0, 0, 0,     0,    0, 0, 1, bexp(40));
        add("rel8",       1,    0, 0, 1, 0,     0,    0, 0, 1, bexp(40));

        rnd = 14'd5;
        foreach (tbl[i]) begin
            repeat (tbl[i].n) step(tbl[i].ms, tbl[i].hs, tbl[i].key);
            chk_all(tbl[i].nm, tbl[i].l, tbl[i].rt, tbl[i].rv,
                    tbl[i].fs, tbl[i].le, tbl[i].b);
        end

        // Fresh reset, then three valid rounds for the best-time tracker.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all("reset2", 0, 0, 0, 0, 1, FF);
        @(negedge clk);
        rst_n = 1'b1;
        best_m = FF;
        do_round(2, 5, 0, 1'b0, 300);
        chk("best.r1", int'(best_time), bexp(300));
        do_round(2, 17, 0, 1'b1, 180);
        chk("best.r2", int'(best_time), bexp(180));
        do_round(2, 0, 0, 1'b0, 250);
        chk("best.r3", int'(best_time), bexp(180));

        // Reset while in WAIT.
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (N) step(1'b0, 1'b1, 1'b1);
        repeat (20) step(1'b1, 1'b0, 1'b1);
        chk("midrst.pre.ledr", int'(ledr), 'h3FF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all("midrst", 0, 0, 0, 0, 1, FF);
        @(negedge clk);
        rst_n = 1'b1;
        best_m = FF;
        step(1'b1, 1'b1, 1'b1);
        chk_all("midrst.idle", 0, 0, 0, 0, 1, FF);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            if (kind == 3) kind = 2;
            r  = $urandom_range(0, 40);
            co = 1'($urandom_range(0, 1));
            k  = (kind == 0) ? $urandom_range(0, N - 1)
                             : $urandom_range(0, 250 + r - 1);
            t  = $urandom_range(0, 300);
            if (t == 0) co = 1'b0;
            do_round(kind, r, k, co, t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
